// File: rtl/axi_lite_shadow_regfile.sv
// AXI4-Lite register file with byte strobes, read-only status slots and a
// frame-synchronous shadow copy consumed by the pixel datapath.
module axi_lite_shadow_regfile #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_RO     = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_lite_awaddr,
  input  logic                      s_axi_lite_awvalid,
  output logic                      s_axi_lite_awready,
  input  logic [31:0]               s_axi_lite_wdata,
  input  logic [3:0]                s_axi_lite_wstrb,
  input  logic                      s_axi_lite_wvalid,
  output logic                      s_axi_lite_wready,
  output logic [1:0]                s_axi_lite_bresp,
  output logic                      s_axi_lite_bvalid,
  input  logic                      s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_lite_araddr,
  input  logic                      s_axi_lite_arvalid,
  output logic                      s_axi_lite_arready,
  output logic [31:0]               s_axi_lite_rdata,
  output logic [1:0]                s_axi_lite_rresp,
  output logic                      s_axi_lite_rvalid,
  input  logic                      s_axi_lite_rready,
  input  logic                      frame_sync,
  input  logic [NUM_RO*32-1:0]      status_in,
  output logic [NUM_REGS*32-1:0]    regs_live,
  output logic [NUM_REGS*32-1:0]    regs_shadow,
  output logic                      update_pending
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned NUM_RW = NUM_REGS - NUM_RO;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_WADDR, W_WDATA, W_WRITE, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  wr_state_e         wr_state, wr_next;
  rd_state_e         rd_state, rd_next;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              rd_stage;
  logic              aw_hs, w_hs, ar_hs;
  logic              wr_ok, wr_commit, rd_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       rd_val_c;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  assign aw_hs     = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs      = s_axi_lite_wvalid && s_axi_lite_wready;
  assign ar_hs     = s_axi_lite_arvalid && s_axi_lite_arready;
  assign wr_ok     = wr_word < WORD_W'(NUM_RW);
  assign wr_idx    = wr_word[IDX_W-1:0];
  assign wr_commit = (wr_state == W_WRITE) && wr_ok;
  assign rd_ok     = rd_word < WORD_W'(NUM_REGS);

  // Write channel next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) wr_next = W_WRITE;
        else if (s_axi_lite_awvalid)                 wr_next = W_WDATA;
        else if (s_axi_lite_wvalid)                  wr_next = W_WADDR;
      end
      W_WDATA: if (s_axi_lite_wvalid)  wr_next = W_WRITE;
      W_WADDR: if (s_axi_lite_awvalid) wr_next = W_WRITE;
      W_WRITE: wr_next = W_RESP;
      W_RESP:  if (s_axi_lite_bready)  wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write channel state, handshake flags and captured transaction
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state           <= W_IDLE;
      s_axi_lite_awready <= 1'b1;
      s_axi_lite_wready  <= 1'b1;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= RESP_OKAY;
      wr_word            <= '0;
      wr_data            <= '0;
      wr_strb            <= '0;
    end else begin
      wr_state           <= wr_next;
      s_axi_lite_awready <= (wr_next == W_IDLE) || (wr_next == W_WADDR);
      s_axi_lite_wready  <= (wr_next == W_IDLE) || (wr_next == W_WDATA);
      s_axi_lite_bvalid  <= (wr_next == W_RESP);
      if (aw_hs) wr_word <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wr_data <= s_axi_lite_wdata;
        wr_strb <= s_axi_lite_wstrb;
      end
      if (wr_state == W_WRITE) s_axi_lite_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // A commit on the same edge as frame_sync stays pending for the next frame
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)        update_pending <= 1'b0;
    else if (wr_commit)  update_pending <= 1'b1;
    else if (frame_sync) update_pending <= 1'b0;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < NUM_RW) begin : g_rw
      logic [31:0] live_q, shadow_q;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          live_q   <= '0;
          shadow_q <= '0;
        end else begin
          if (wr_commit && (wr_idx == IDX_W'(i))) begin
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) live_q[8*b +: 8] <= wr_data[8*b +: 8];
          end
          if (frame_sync) shadow_q <= live_q;
        end
      end
      assign regs_live[32*i +: 32]   = live_q;
      assign regs_shadow[32*i +: 32] = shadow_q;
    end else begin : g_ro
      assign regs_live[32*i +: 32]   = '0;
      assign regs_shadow[32*i +: 32] = '0;
    end
  end

  // Read source: live RW register or external status slot
  always_comb begin
    rd_val_c = '0;
    for (int i = 0; i < int'(NUM_RW); i++)
      if (rd_word == WORD_W'(i)) rd_val_c = regs_live[32*i +: 32];
    for (int k = 0; k < int'(NUM_RO); k++)
      if (rd_word == WORD_W'(int'(NUM_RW) + k)) rd_val_c = status_in[32*k +: 32];
  end

  // FETCH spans two cycles: sample on the first edge, present on the second
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (s_axi_lite_arvalid) rd_next = R_FETCH;
      R_FETCH: if (rd_stage)           rd_next = R_DATA;
      R_DATA:  if (s_axi_lite_rready)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state           <= R_IDLE;
      rd_stage           <= 1'b0;
      rd_word            <= '0;
      s_axi_lite_arready <= 1'b1;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rdata   <= '0;
      s_axi_lite_rresp   <= RESP_OKAY;
    end else begin
      rd_state           <= rd_next;
      rd_stage           <= (rd_state == R_FETCH) && !rd_stage;
      s_axi_lite_arready <= (rd_next == R_IDLE);
      s_axi_lite_rvalid  <= (rd_next == R_DATA);
      if (ar_hs) rd_word <= s_axi_lite_araddr[ADDR_WIDTH-1:2];
      if ((rd_state == R_FETCH) && !rd_stage) begin
        s_axi_lite_rdata <= rd_ok ? rd_val_c : 32'h0;
        s_axi_lite_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_shadow_regfile.sv
// Directed self-checking bench for axi_lite_shadow_regfile (16 regs, 2 status slots).
module tb_axi_lite_shadow_regfile;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [7:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         frame_sync;
  logic [63:0]  status_in;
  logic [511:0] regs_live, regs_shadow;
  logic         update_pending;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_lite_shadow_regfile #(.NUM_REGS(16), .ADDR_WIDTH(8), .NUM_RO(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .frame_sync(frame_sync), .status_in(status_in),
    .regs_live(regs_live), .regs_shadow(regs_shadow), .update_pending(update_pending)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_frame_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (!bvalid) begin
      failures++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    checks++;
    if (!rvalid) begin
      failures++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("FAIL reset_ready got=%b required 111", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, update_pending} !== 3'b000) begin
      failures++; $display("FAIL reset_valid got=%b required 000", {bvalid, rvalid, update_pending});
    end
    checks++;
    if (regs_live !== '0 || regs_shadow !== '0) begin
      failures++; $display("FAIL reset_regs live/shadow not zero");
    end
    checks++;
    if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      failures++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
    end
  endtask

  task automatic test_write_same_cycle();
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h0000_0A5C; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      failures++; $display("FAIL wr_first_edge bvalid=%b awready=%b required 0 0", bvalid, awready);
    end
    tick();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("FAIL wr_bvalid bvalid=%b bresp=%b required 1 00", bvalid, bresp);
    end
    checks++;
    if (regs_live[63:32] !== 32'h0000_0A5C) begin
      failures++; $display("FAIL wr_live1 got=%h required 00000a5c", regs_live[63:32]);
    end
    checks++;
    if (regs_shadow[63:32] !== 32'h0 || update_pending !== 1'b1) begin
      failures++; $display("FAIL wr_shadow_hold shadow=%h pending=%b required 0 1",
                           regs_shadow[63:32], update_pending);
    end
    tick();
    checks++;
    if (bvalid !== 1'b1) begin
      failures++; $display("FAIL wr_bvalid_hold got=%b required 1", bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("FAIL wr_bdone bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
    pulse_frame_sync();
    checks++;
    if (regs_shadow[63:32] !== 32'h0000_0A5C || update_pending !== 1'b0) begin
      failures++; $display("FAIL wr_shadow_commit shadow=%h pending=%b required 00000a5c 0",
                           regs_shadow[63:32], update_pending);
    end
  endtask

  task automatic test_split_write();
    logic [1:0] resp;
    int n;
    axi_write(8'h0C, 32'h1122_3344, 4'hF, resp);
    awaddr = 8'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    repeat (3) tick();
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b1 || awready !== 1'b0) begin
      failures++; $display("FAIL split_wait bvalid=%b wready=%b awready=%b required 0 1 0",
                           bvalid, wready, awready);
    end
    wdata = 32'h0000_BB00; wstrb = 4'b0010; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("FAIL split_resp bvalid=%b bresp=%b required 1 00", bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (regs_live[127:96] !== 32'h1122_BB44) begin
      failures++; $display("FAIL split_strobe got=%h required 1122bb44", regs_live[127:96]);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp;
    logic [511:0] snap;
    pulse_frame_sync();
    snap = regs_live;
    axi_write(8'h3C, 32'hFFFF_FFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b10 || regs_live !== snap || update_pending !== 1'b0) begin
      failures++; $display("FAIL ro_write bresp=%b pending=%b changed=%b required 10 0 0",
                           resp, update_pending, regs_live !== snap);
    end
    axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b10 || regs_live !== snap || update_pending !== 1'b0) begin
      failures++; $display("FAIL oob_write bresp=%b pending=%b changed=%b required 10 0 0",
                           resp, update_pending, regs_live !== snap);
    end
    axi_write(8'h10, 32'hFFFF_FFFF, 4'h0, resp);
    checks++;
    if (resp !== 2'b00 || regs_live[159:128] !== 32'h0 || update_pending !== 1'b1) begin
      failures++; $display("FAIL zero_strb bresp=%b reg4=%h pending=%b required 00 0 1",
                           resp, regs_live[159:128], update_pending);
    end
  endtask

  task automatic test_read_status();
    logic [31:0] d;
    logic [1:0]  resp;
    araddr = 8'h3C; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      failures++; $display("FAIL rd_edge_t rvalid=%b arready=%b required 0 0", rvalid, arready);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL rd_edge_t1 rvalid=%b required 0", rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rresp !== 2'b00) begin
      failures++; $display("FAIL rd_status1 rvalid=%b rdata=%h rresp=%b required 1 deadbeef 00",
                           rvalid, rdata, rresp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
        failures++; $display("FAIL rd_hold cycle=%0d rvalid=%b rdata=%h required 1 deadbeef",
                             i, rvalid, rdata);
      end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL rd_done rvalid=%b arready=%b required 0 1", rvalid, arready);
    end
    axi_read(8'h38, d, resp);
    checks++;
    if (d !== 32'h0BAD_F00D || resp !== 2'b00) begin
      failures++; $display("FAIL rd_status0 rdata=%h rresp=%b required 0badf00d 00", d, resp);
    end
    axi_read(8'h0D, d, resp);
    checks++;
    if (d !== 32'h1122_BB44 || resp !== 2'b00) begin
      failures++; $display("FAIL rd_reg3 rdata=%h rresp=%b required 1122bb44 00", d, resp);
    end
    axi_read(8'h44, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("FAIL rd_oob rdata=%h rresp=%b required 0 10", d, resp);
    end
  endtask

  task automatic test_frame_sync_collision();
    logic [1:0] resp;
    axi_write(8'h08, 32'h11, 4'hF, resp);
    pulse_frame_sync();
    checks++;
    if (regs_shadow[95:64] !== 32'h11 || update_pending !== 1'b0) begin
      failures++; $display("FAIL coll_setup shadow2=%h pending=%b required 11 0",
                           regs_shadow[95:64], update_pending);
    end
    awaddr = 8'h08; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    checks++;
    if (regs_shadow[95:64] !== 32'h11 || regs_live[95:64] !== 32'h55 || update_pending !== 1'b1) begin
      failures++; $display("FAIL coll_edge shadow2=%h live2=%h pending=%b required 11 55 1",
                           regs_shadow[95:64], regs_live[95:64], update_pending);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    pulse_frame_sync();
    checks++;
    if (regs_shadow[95:64] !== 32'h55 || update_pending !== 1'b0) begin
      failures++; $display("FAIL coll_next shadow2=%h pending=%b required 55 0",
                           regs_shadow[95:64], update_pending);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  resp;
    awaddr = 8'h14; awvalid = 1'b1; wdata = 32'hCAFE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    araddr = 8'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      failures++; $display("FAIL mid_setup bvalid=%b rvalid=%b required 1 1", bvalid, rvalid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || update_pending !== 1'b0) begin
      failures++; $display("FAIL mid_reset bvalid=%b rvalid=%b pending=%b required 0 0 0",
                           bvalid, rvalid, update_pending);
    end
    checks++;
    if (regs_live !== '0 || regs_shadow !== '0) begin
      failures++; $display("FAIL mid_reset_regs live/shadow not zero");
    end
    tick();
    #2 aresetn = 1'b1;
    tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      failures++; $display("FAIL mid_release got=%b required 11100",
                           {awready, wready, arready, bvalid, rvalid});
    end
    axi_write(8'h08, 32'h77, 4'hF, resp);
    checks++;
    if (resp !== 2'b00 || regs_live[95:64] !== 32'h77) begin
      failures++; $display("FAIL post_write bresp=%b reg2=%h required 00 77", resp, regs_live[95:64]);
    end
    axi_read(8'h08, d, resp);
    checks++;
    if (d !== 32'h77 || resp !== 2'b00) begin
      failures++; $display("FAIL post_read rdata=%h rresp=%b required 77 00", d, resp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; frame_sync = 1'b0;
    status_in = {32'hDEAD_BEEF, 32'h0BAD_F00D};
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    test_reset();
    test_write_same_cycle();
    test_split_write();
    test_slverr();
    test_read_status();
    test_frame_sync_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
